// File: rtl/udp_tx_frame_arbiter_if.sv
// udp_tx_frame_arbiter_if
// Bundle of AXI-stream signals carrying LANES 8-bit byte lanes.
// The source side of the arbiter uses LANES=N and the payload side uses LANES=1.
//   tdata  : LANES*8 bits, lane i at [8i+7:8i]
//   tvalid : per-lane valid
//   tready : per-lane ready
//   tlast  : per-lane end of frame
//   tuser  : per-lane bad-frame flag
// Modports:
//   master : drives data/valid/last/user and receives ready
//   slave  : receives data/valid/last/user and drives ready
interface udp_tx_frame_arbiter_if #(
  parameter int LANES = 1
);
  logic [LANES*8-1:0] tdata;
  logic [LANES-1:0]   tvalid;
  logic [LANES-1:0]   tready;
  logic [LANES-1:0]   tlast;
  logic [LANES-1:0]   tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/udp_tx_frame_arbiter.sv
// udp_tx_frame_arbiter
// Frame-level round-robin arbiter that merges N 8-bit AXI-stream sources into
// the single UDP TX payload stream. A grant is held from the first beat to tlast,
// so frames are never interleaved. Pass-through is combinational while a frame
// is owned; there is one idle (arbitration) cycle between frames.
//
// Optional build macro UDP_TX_ARB_TIMEOUT_EN adds a stall watchdog: if the granted
// source withholds data for TIMEOUT cycles, a 0x00 beat with tlast=1/tuser=1 is
// emitted, and the rest of the source frame is then drained and discarded.
//
// Ports:
//   clk, rst     : core clock, synchronous active-high reset
//   s_axis       : N source lanes (slave modport)
//   m_axis       : payload stream towards the TX FIFO (master modport, 1 lane)
//   grant_valid  : a frame is currently owned
//   grant_index  : owning source index
//   frame_count  : frames forwarded by normal tlast (wraps)
//   abort_count  : frames terminated by the watchdog (wraps, 0 without the macro)
//
// State | meaning
// IDLE  | no owner; pick the first valid source at or after the pointer
// ACTIVE| pass-through of the granted source until tlast
// ABORT | (watchdog) emit the terminating error beat
// DRAIN | (watchdog) discard the source's remaining beats up to its tlast
module udp_tx_frame_arbiter #(
  parameter int N         = 2,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  udp_tx_frame_arbiter_if.slave  s_axis,
  udp_tx_frame_arbiter_if.master m_axis,
  output logic                   grant_valid,
  output logic [2:0]             grant_index,
  output logic [CNT_WIDTH-1:0]   frame_count,
  output logic [15:0]            abort_count
);

  if (N < 2 || N > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("udp_tx_frame_arbiter: N must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
`ifdef UDP_TX_ARB_TIMEOUT_EN
    ,
    ABORT  = 2'd2,
    DRAIN  = 2'd3
`endif
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [2:0]           gidx_q, gidx_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [3:0] cand;
  logic [2:0] nxt_ptr;
  logic [7:0] g_data;
  logic       g_valid, g_last, g_user;
  logic       src_ready;
  logic [N-1:0] tready_vec;

`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [15:0]     abort_cnt_q, abort_cnt_d;
`endif

  // Rotating priority: candidate k is (ptr + k) mod N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + 4'(k);
      if (cand >= 4'(N)) cand = cand - 4'(N);
      for (int i = 0; i < N; i++) begin
        if (!pick_found && cand == 4'(i) && s_axis.tvalid[i]) begin
          pick_found = 1'b1;
          pick_idx   = 3'(i);
        end
      end
    end
  end

  // Mux of the granted source and steering of its ready.
  always_comb begin
    g_data     = '0;
    g_valid    = 1'b0;
    g_last     = 1'b0;
    g_user     = 1'b0;
    tready_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (gidx_q == 3'(i)) begin
        g_data        = s_axis.tdata[i*8 +: 8];
        g_valid       = s_axis.tvalid[i];
        g_last        = s_axis.tlast[i];
        g_user        = s_axis.tuser[i];
        tready_vec[i] = src_ready;
      end
    end
    s_axis.tready = tready_vec;
  end

  assign nxt_ptr = (gidx_q == 3'(N - 1)) ? 3'd0 : gidx_q + 3'd1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gidx_d        = gidx_q;
    frame_cnt_d   = frame_cnt_q;
    grant_valid   = 1'b0;
    src_ready     = 1'b0;
    m_axis.tdata  = '0;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tuser  = 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    wd_d          = wd_q;
    abort_cnt_d   = abort_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          state_d = ACTIVE;
`ifdef UDP_TX_ARB_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      ACTIVE: begin
        grant_valid   = 1'b1;
        m_axis.tdata  = g_data;
        m_axis.tvalid = g_valid;
        m_axis.tlast  = g_last;
        m_axis.tuser  = g_user;
        src_ready     = m_axis.tready;
        if (g_valid && m_axis.tready) begin
`ifdef UDP_TX_ARB_TIMEOUT_EN
          wd_d = '0;
`endif
          if (g_last) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            ptr_d       = nxt_ptr;
            state_d     = IDLE;
          end
        end
`ifdef UDP_TX_ARB_TIMEOUT_EN
        // Only a silent source counts; downstream back-pressure never aborts.
        if (!g_valid) begin
          wd_d = wd_q + 1'b1;
          if (wd_q == WD_W'(TIMEOUT - 2)) state_d = ABORT;
        end
`endif
      end
`ifdef UDP_TX_ARB_TIMEOUT_EN
      ABORT: begin
        grant_valid   = 1'b1;
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = 1'b1;
        m_axis.tuser  = 1'b1;
        if (m_axis.tready) begin
          abort_cnt_d = abort_cnt_q + 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        // Source keeps ownership until its own tlast; the frame is discarded.
        grant_valid = 1'b1;
        src_ready   = 1'b1;
        if (g_valid && g_last) begin
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      frame_cnt_q <= '0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      wd_q        <= '0;
      abort_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
      abort_cnt_q <= abort_cnt_d;
`endif
    end
  end

  assign grant_index = gidx_q;
  assign frame_count = frame_cnt_q;
`ifdef UDP_TX_ARB_TIMEOUT_EN
  assign abort_count = abort_cnt_q;
`else
  assign abort_count = '0;
`endif

endmodule

// File: tb/tb_udp_tx_frame_arbiter.sv
module tb_udp_tx_frame_arbiter;
  localparam int N         = 3;
  localparam int TIMEOUT   = 16;
  localparam int CNT_WIDTH = 32;

  typedef struct packed { logic [7:0] data; logic last; logic user; } beat_t;
  typedef struct packed { logic [2:0] src; logic [7:0] data; logic last; logic user; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  udp_tx_frame_arbiter_if #(.LANES(N)) s_if ();
  udp_tx_frame_arbiter_if #(.LANES(1)) m_if ();
  logic                 grant_valid;
  logic [2:0]           grant_index;
  logic [CNT_WIDTH-1:0] frame_count;
  logic [15:0]          abort_count;

  udp_tx_frame_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst), .s_axis(s_if.slave), .m_axis(m_if.master),
    .grant_valid(grant_valid), .grant_index(grant_index),
    .frame_count(frame_count), .abort_count(abort_count)
  );

  beat_t src_q[N][$];   // per-source beats still to be offered
  exp_t  exp_q[$];      // scoreboard of beats expected on m_axis, in order
  int n_pass = 0, n_total = 0, cyc = 0, ready_mode = 1;
  // reference model: round-robin pointer and counters
  int mdl_ptr = 0, mdl_frames = 0, mdl_aborts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drive_sources();
    logic [N*8-1:0] d;
    logic [N-1:0] v, l, u;
    d = '0; v = '0; l = '0; u = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        d[i*8 +: 8] = src_q[i][0].data;
        v[i] = 1'b1;
        l[i] = src_q[i][0].last;
        u[i] = src_q[i][0].user;
      end
    end
    s_if.tdata = d; s_if.tvalid = v; s_if.tlast = l; s_if.tuser = u;
  endtask

  // Source and sink driver: handshakes are sampled on the negedge, updates follow the posedge.
  initial begin : driver
    logic [N-1:0] xfer;
    s_if.tdata = '0; s_if.tvalid = '0; s_if.tlast = '0; s_if.tuser = '0;
    m_if.tready = 1'b0;
    forever begin
      @(negedge clk);
      xfer = s_if.tvalid & s_if.tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      drive_sources();
      case (ready_mode)
        0: m_if.tready = 1'b0;
        1: m_if.tready = 1'b1;
        2: m_if.tready = ~m_if.tready;
        default: m_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every output beat is popped from the scoreboard and compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_if.tvalid[0] && m_if.tready[0]) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 64'(m_if.tvalid), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("beat{src,data,last,user}",
              64'({grant_index, m_if.tdata, m_if.tlast, m_if.tuser}), 64'(e));
        end
      end
    end
  end

  // Queue a frame on a source; the first n_exp beats are expected on the output.
  task automatic load(input int src, input int len, input bit with_last, input int n_exp, input int base);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + k);
      b.last = with_last && (k == len - 1);
      b.user = (base < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      src_q[src].push_back(b);
      if (k < n_exp) exp_q.push_back('{src: 3'(src), data: b.data, last: b.last, user: b.user});
    end
  endtask

  // Reference arbitration: sources with pending frames stay valid, so each
  // grant goes to the first pending source at or after the pointer.
  task automatic rr_round(input int c0, input int c1, input int c2, input int lmin, input int lmax);
    int cnt[N];
    int s;
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
    for (int guard = 0; guard < 64; guard++) begin
      s = -1;
      for (int k = 0; k < N; k++)
        if (s < 0 && cnt[(mdl_ptr + k) % N] > 0) s = (mdl_ptr + k) % N;
      if (s < 0) break;
      load(s, $urandom_range(lmax, lmin), 1'b1, 1000, -1);
      cnt[s]--;
      mdl_ptr = (s + 1) % N;
      mdl_frames++;
    end
  endtask

  task automatic wait_done(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = all_empty() && exp_q.size() == 0 && !grant_valid;
    end
    chk({name, "_complete"}, 64'(done), 64'd1);
    chk({name, "_frame_count"}, 64'(frame_count), 64'(mdl_frames));
    chk({name, "_abort_count"}, 64'(abort_count), 64'(mdl_aborts));
  endtask

  initial begin : watchdog_timer
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    int t0, t1, beats;
    bit ok;
    logic [N-1:0] ready_seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_grant_valid", 64'(grant_valid), 0);
    chk("rst_grant_index", 64'(grant_index), 0);
    chk("rst_m_tvalid", 64'(m_if.tvalid), 0);
    chk("rst_m_tdata_last_user", 64'({m_if.tdata, m_if.tlast, m_if.tuser}), 0);
    chk("rst_s_tready", 64'(s_if.tready), 0);
    chk("rst_frame_count", 64'(frame_count), 0);
    chk("rst_abort_count", 64'(abort_count), 0);

    // Round-robin: sources 0 and 1 continuously valid, 3-byte frames.
    rr_round(2, 2, 0, 3, 3);
    beats = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 200 && beats < 12; c++) begin
      @(negedge clk);
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        beats++;
        if (beats == 1) t0 = cyc;
        if (beats == 12) t1 = cyc;
      end
    end
    chk("rr_span_with_bubbles", 64'(t1 - t0), 64'd14);
    wait_done("rr");

    // Single source: 0x11..0x14, one-cycle arbitration latency.
    load(0, 4, 1'b1, 4, 8'h11);
    mdl_frames++; mdl_ptr = 1;
    ready_seen = '0; t0 = -100; t1 = -200;
    for (int c = 0; c < 50 && t0 < 0; c++) begin
      @(negedge clk);
      if (s_if.tvalid[0]) t0 = cyc;
    end
    for (int c = 0; c < 50 && t1 < 0; c++) begin
      if (m_if.tvalid[0]) t1 = cyc;
      else @(negedge clk);
    end
    chk("single_latency", 64'(t1 - t0), 64'd1);
    for (int c = 0; c < 20; c++) begin
      ready_seen = ready_seen | s_if.tready;
      @(negedge clk);
    end
    chk("single_grant_index", 64'(grant_index), 0);
    chk("single_src1_ready_low", 64'(ready_seen[1]), 0);
    wait_done("single");

    // No interleave: source 1 arrives mid-way through a 10-byte source 0 frame.
    ready_mode = 2;
    load(0, 10, 1'b1, 10, -1);
    for (int c = 0; c < 100 && src_q[0].size() > 5; c++) @(negedge clk);
    load(1, 3, 1'b1, 3, -1);
    mdl_frames += 2; mdl_ptr = 2;
    wait_done("no_interleave");

    // Back-pressure for 100 cycles with the source valid: no abort, frame held.
    ready_mode = 0;
    load(0, 4, 1'b1, 4, -1);
    repeat (100) @(negedge clk);
    chk("bp_abort_count", 64'(abort_count), 64'(mdl_aborts));
    chk("bp_grant_held", 64'(grant_valid), 64'd1);
    chk("bp_nothing_consumed", 64'(src_q[0].size()), 64'd4);
    ready_mode = 1;
    mdl_frames++; mdl_ptr = 1;
    wait_done("backpressure");

`ifdef UDP_TX_ARB_TIMEOUT_EN
    // Watchdog: source 0 stalls after 2 beats; abort at the 16th idle cycle.
    load(0, 2, 1'b0, 2, -1);
    exp_q.push_back('{src: 3'd0, data: 8'h00, last: 1'b1, user: 1'b1});
    t0 = -100; t1 = -200;
    for (int c = 0; c < 50 && t0 < 0; c++) begin
      @(negedge clk);
      if (src_q[0].size() == 0) t0 = cyc;
    end
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      if (m_if.tvalid[0] && m_if.tlast[0] && m_if.tuser[0]) t1 = cyc;
      else @(negedge clk);
    end
    chk("wd_abort_timing", 64'(t1 - t0), 64'(TIMEOUT - 1));
    repeat (4) @(negedge clk);
    load(0, 3, 1'b1, 0, -1);
    load(1, 3, 1'b1, 3, -1);
    mdl_aborts++; mdl_frames++; mdl_ptr = 2;
    wait_done("watchdog");
`endif

    // Reset mid-frame: rst after beat 2 of a 6-beat source 1 frame.
    load(1, 6, 1'b1, 2, -1);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (m_if.tvalid[0] && m_if.tready[0] && src_q[1].size() == 5) ok = 1'b1;
    end
    chk("rst_mid_sync", 64'(ok), 64'd1);
    ready_mode = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    src_q[1].delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    mdl_ptr = 0; mdl_frames = 0; mdl_aborts = 0;
    chk("rst_mid_m_tvalid", 64'(m_if.tvalid), 0);
    chk("rst_mid_grant_valid", 64'(grant_valid), 0);
    chk("rst_mid_frame_count", 64'(frame_count), 64'(mdl_frames));
    chk("rst_mid_abort_count", 64'(abort_count), 64'(mdl_aborts));
    ready_mode = 1;
    rr_round(1, 1, 0, 2, 5);
    wait_done("after_reset");

    // Randomized rounds with random sink readiness.
    ready_mode = 3;
    for (int r = 0; r < 6; r++) begin
      rr_round($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1, 8);
      wait_done("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/udp_tx_frame_arbiter.md
Name: udp_tx_frame_arbiter

Overview:
- Frame-level round-robin arbiter that shares the single 8-bit UDP TX payload stream between N AXI-stream sources, e.g. accelerator partition output plus status/echo generators.
- Sits between the source streams and the TX payload FIFO that feeds the Ethernet core. Runs in the 125 MHz core clock domain.
- A grant is held from the first beat to tlast, so frames are never interleaved.
- Optional stall watchdog terminates frames whose source stops delivering data.

Parameters:
- N, 2, number of requesting sources (2..8).
- TIMEOUT, 1024, idle cycles of the granted source before abort (watchdog build only; ≥2).
- CNT_WIDTH, 32, width of the forwarded-frame counter.

Ports:
- clk  in  1  core clock, 125 MHz
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  N*8  source data, source i at bits [8i+7:8i]
- s_axis_tvalid  in  N  per-source valid
- s_axis_tready  out  N  per-source ready
- s_axis_tlast  in  N  per-source end of frame
- s_axis_tuser  in  N  per-source bad-frame flag
- m_axis_tdata  out  8  to TX payload FIFO
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tuser  out  1
- grant_valid  out  1  high while a frame is owned (ACTIVE, ABORT, DRAIN)
- grant_index  out  3  index of the owning source
- frame_count  out  CNT_WIDTH  frames forwarded by normal tlast
- abort_count  out  16  frames terminated by the watchdog (stays 0 without the macro)

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high.
  - State goes to IDLE; round-robin pointer, both counters, grant_index and the watchdog counter clear to 0.
  - All s_axis_tready and m_axis_tvalid/tlast/tuser/tdata read 0; grant_valid reads 0.
  - rst mid-frame abandons the frame without emitting tlast; the downstream FIFO relies on its own reset.
- IDLE:
  - m_axis_tvalid=0 and all s_axis_tready=0.
  - If any s_axis_tvalid is high, select the first valid index at or after the pointer (wrapping modulo N).
  - Register it in grant_index and go to ACTIVE next cycle. Arbitration latency is 1 cycle.
- ACTIVE: combinational pass-through of the granted source g.
  - m_axis_tdata/tvalid/tlast/tuser follow source g.
  - s_axis_tready[g]=m_axis_tready; all other s_axis_tready=0.
  - A beat transfers when m_axis_tvalid && m_axis_tready.
  - On a beat with tlast: frame_count+1 (wraps), pointer=(g+1) mod N, next state IDLE.
  - This gives one bubble cycle between consecutive frames.
- Fairness: with all N sources continuously valid, grants rotate 0,1,...,N-1,0, and so on.
- Single-beat frames (tvalid and tlast on the first beat) complete in ACTIVE in one cycle.
- Counter saturation: none; frame_count wraps, abort_count wraps at 16 bits.
- Non-granted sources may change tvalid freely; the arbiter samples their state only in IDLE.

Optional Feature:
- Macro: UDP_TX_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in ACTIVE. It clears on any transfer beat and on entry to ACTIVE.
  - It increments while s_axis_tvalid[g]=0. Back-pressure from m_axis_tready=0 with valid high does not count.
  - When it reaches TIMEOUT-1, go to ABORT.
- ABORT:
  - Drive m_axis_tvalid=1, tdata=0x00, tlast=1, tuser=1; all s_axis_tready=0.
  - On m_axis_tready: abort_count+1 and go to DRAIN.
- DRAIN:
  - m_axis_tvalid=0; s_axis_tready[g]=1 and source beats are discarded.
  - On a source beat with tlast: pointer=(g+1) mod N, next state IDLE.
  - If the source tlast never arrives, DRAIN holds. This is intentional: the source owns recovery.
- Not defined: no ABORT/DRAIN states; ACTIVE holds indefinitely; abort_count is tied to 0.

Test Plan:
- Single source: N=2, source 0 sends 4 bytes 0x11..0x14 with tlast on 0x14, m_axis_tready=1 → m sees the same 4 beats starting 1 cycle after tvalid; grant_index=0; frame_count=1; s_axis_tready[1]=0 throughout.
- Round-robin: both sources continuously valid with 3-byte frames → output order src0, src1, src0, src1; one idle cycle between frames; frame_count=4 after 4 frames.
- No interleave: source 1 raises valid mid-way through a 10-byte source 0 frame; m_axis_tready toggles 1/0 each cycle → all 10 source 0 bytes are contiguous before any source 1 byte; no beat is lost or duplicated.
- Reset mid-frame: assert rst for 1 cycle after beat 2 of 6 → next cycle m_axis_tvalid=0, grant_valid=0, counters=0; the next arbitration starts at source 0.
- Watchdog (macro on, TIMEOUT=16): source 0 sends 2 beats then drops valid for 20 cycles → at the 16th idle cycle m emits 0x00 with tlast=1 and tuser=1; abort_count=1; later source 0 beats up to its tlast are dropped; then source 1 is granted.
- Watchdog back-pressure (macro on, TIMEOUT=16): source valid held high, m_axis_tready=0 for 100 cycles → no abort; abort_count=0; the frame completes normally once ready returns.
